// File: rtl/larpix_pkg.sv
// Shared definitions for the LArPix configuration responder: packet field
// layout, packet-declare codes, broadcast ID and responder FSM states.
package larpix_pkg;

  typedef enum logic [1:0] {
    DATA_OP         = 2'd0,
    TEST_OP         = 2'd1,
    CONFIG_WRITE_OP = 2'd2,
    CONFIG_READ_OP  = 2'd3
  } declare_t;

  localparam int DECL_LSB       = 0;
  localparam int DECL_W         = 2;
  localparam int CHIP_LSB       = 2;
  localparam int ADDR_LSB       = 10;
  localparam int DATA_LSB       = 18;
  localparam int FIELD_W        = 8;
  localparam int DOWNSTREAM_BIT = 62;

  localparam int GLOBAL_ID = 255;

  typedef enum logic [2:0] {
    IDLE,
    UNLOAD,
    CAPTURE,
    DECODE,
    RDWAIT,
    SEND,
    TXWAIT
  } state_t;

endpackage

// File: rtl/config_responder.sv
// Serial-packet configuration responder: unloads words from uart_rx, services
// register-map writes/reads addressed to this chip, and forwards everything else.
module config_responder #(
  parameter int WIDTH     = 64,
  parameter int REGNUM    = 182,
  parameter int GLOBAL_ID = larpix_pkg::GLOBAL_ID
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       chip_id,
  input  logic             rx_empty,
  input  logic [WIDTH-2:0] rx_data,
  input  logic             parity_error,
  output logic             uld_rx_data,
  input  logic             tx_busy,
  output logic             ld_tx_data,
  output logic [WIDTH-1:0] tx_data,
  output logic             regmap_we,
  output logic [7:0]       regmap_addr,
  output logic [7:0]       regmap_wdata,
  input  logic [7:0]       regmap_rdata,
  output logic [7:0]       parity_err_cnt
);
  import larpix_pkg::*;

  localparam logic [7:0] GID      = 8'(GLOBAL_ID);
  localparam logic [8:0] REGNUM_W = 9'(REGNUM);

  state_t           state_p0, state_nxt;
  logic [WIDTH-2:0] pkt_p0;
  logic             perr_p0;
  logic [WIDTH-2:0] reply;
  declare_t         pkt_decl;
  logic [7:0]       pkt_chip, pkt_addr, pkt_data;
  logic             chip_match, addr_ok, is_cfg;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [WIDTH-1:0] with_parity(input logic [WIDTH-2:0] p);
    return {~^p, p};
  endfunction

  assign pkt_decl   = declare_t'(pkt_p0[DECL_LSB +: DECL_W]);
  assign pkt_chip   = pkt_p0[CHIP_LSB +: FIELD_W];
  assign pkt_addr   = pkt_p0[ADDR_LSB +: FIELD_W];
  assign pkt_data   = pkt_p0[DATA_LSB +: FIELD_W];
  assign chip_match = (pkt_chip == chip_id) || (pkt_chip == GID);
  assign addr_ok    = {1'b0, pkt_addr} < REGNUM_W;
  assign is_cfg     = (pkt_decl == CONFIG_WRITE_OP) || (pkt_decl == CONFIG_READ_OP);

  // The register map sees the captured packet fields directly; the read data
  // therefore settles by RDWAIT, one cycle after DECODE exposes the address.
  assign regmap_addr  = pkt_addr;
  assign regmap_wdata = pkt_data;

  always_comb begin
    reply = '0;
    reply[DECL_LSB +: DECL_W]  = CONFIG_READ_OP;
    reply[CHIP_LSB +: FIELD_W] = chip_id;
    reply[ADDR_LSB +: FIELD_W] = pkt_addr;
    reply[DATA_LSB +: FIELD_W] = regmap_rdata;
    reply[DOWNSTREAM_BIT]      = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_p0 <= IDLE;
    else          state_p0 <= state_nxt;
  end

  always_comb begin
    state_nxt   = state_p0;
    uld_rx_data = 1'b0;
    ld_tx_data  = 1'b0;
    regmap_we   = 1'b0;
    case (state_p0)
      IDLE:    if (!rx_empty) state_nxt = UNLOAD;
      UNLOAD: begin
        uld_rx_data = 1'b1;
        state_nxt   = CAPTURE;
      end
      CAPTURE: state_nxt = DECODE;
      DECODE: begin
        if (perr_p0) begin
          state_nxt = IDLE;
        end else if (is_cfg && chip_match) begin
          if (!addr_ok) begin
            state_nxt = IDLE;
          end else if (pkt_decl == CONFIG_WRITE_OP) begin
            regmap_we = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = RDWAIT;
          end
        end else begin
          state_nxt = SEND;
        end
      end
      RDWAIT:  state_nxt = SEND;
      SEND: begin
        if (!tx_busy) begin
          ld_tx_data = 1'b1;
          state_nxt  = TXWAIT;
        end
      end
      TXWAIT:  if (tx_busy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture / decode / reply stage registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_p0         <= '0;
      perr_p0        <= 1'b0;
      tx_data        <= '0;
      parity_err_cnt <= '0;
    end else begin
      if (state_p0 == CAPTURE) begin
        pkt_p0  <= rx_data;
        perr_p0 <= parity_error;
      end
      if (state_p0 == DECODE && perr_p0)
        parity_err_cnt <= sat_inc(parity_err_cnt);
      if (state_p0 == DECODE && state_nxt == SEND)
        tx_data <= with_parity(pkt_p0);
      if (state_p0 == RDWAIT)
        tx_data <= with_parity(reply);
    end
  end

endmodule

// File: doc/config_responder.md
CONFIG_RESPONDER -- requirements
Module: config_responder

Interface
REQ-001 Parameter WIDTH, 64, serial packet width including the parity bit.
REQ-002 Parameter REGNUM, 182, number of implemented register-map addresses.
REQ-003 Parameter GLOBAL_ID, 255, broadcast chip ID.
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 chip_id  in  8  this chip's ID; static during operation.
REQ-007 rx_empty  in  1  uart_rx status; 0 means a word is held.
REQ-008 rx_data  in  63  received packet, bits [62:0].
REQ-009 parity_error  in  1  uart_rx parity flag for the held word.
REQ-010 uld_rx_data  out  1  unload strobe to uart_rx.
REQ-011 tx_busy  in  1  uart_tx busy flag.
REQ-012 ld_tx_data  out  1  load strobe to uart_tx.
REQ-013 tx_data  out  64  outgoing packet; bit 63 is odd parity.
REQ-014 regmap_we  out  1  register-map write strobe.
REQ-015 regmap_addr  out  8  register-map address.
REQ-016 regmap_wdata  out  8  register-map write data.
REQ-017 regmap_rdata  in  8  read data, valid one cycle after regmap_addr changes.
REQ-018 parity_err_cnt  out  8  saturating count of dropped bad-parity packets.

Function
REQ-019 Packet fields: [1:0] declare (0 data, 1 test, 2 config write, 3 config read); [9:2] chip ID; [17:10] address; [25:18] data; [62] downstream marker.
REQ-020 FSM states: IDLE, UNLOAD, CAPTURE, DECODE, RDWAIT, SEND, TXWAIT.
REQ-021 IDLE -> UNLOAD when rx_empty==0; UNLOAD drives uld_rx_data=1 for exactly one cycle.
REQ-022 CAPTURE registers rx_data and parity_error into a 63-bit packet register on the cycle after UNLOAD; next state is DECODE.
REQ-023 DECODE with parity_error=1: drop the packet, increment parity_err_cnt (saturating at 255), and return to IDLE.
REQ-024 A packet matches when its chip ID equals chip_id or GLOBAL_ID.
REQ-025 Config write, matching, address < REGNUM: regmap_we=1 for one cycle with the address and data fields; send no reply; return to IDLE.
REQ-026 Config write or read with address >= REGNUM and matching chip ID: ignore; no write, no reply; return to IDLE.
REQ-027 Config read, matching, address < REGNUM: drive regmap_addr and enter RDWAIT for one cycle.
REQ-028 The read reply is built in RDWAIT: declare=3, chip ID = own chip_id (also for global reads), same address, data=regmap_rdata, bit 62=1, bits [61:26]=0.
REQ-029 A non-matching packet, or any declare 0/1 packet, is forwarded unchanged in bits [62:0] and enters SEND.
REQ-030 tx_data[63] SHALL equal the XNOR-reduction of tx_data[62:0] (odd parity), recomputed for every outgoing packet.
REQ-031 SEND holds until tx_busy==0, then drives ld_tx_data=1 for exactly one cycle and enters TXWAIT.
REQ-032 TXWAIT returns to IDLE once tx_busy==1 is observed; no second ld_tx_data is issued before then.
REQ-033 tx_data is stable from the ld_tx_data cycle until TXWAIT exits.
REQ-034 uld_rx_data is never asserted outside UNLOAD, so a new word is not unloaded while a send is pending.
REQ-035 regmap_we and ld_tx_data are never asserted in the same cycle.

Reset
REQ-036 While reset_n=0: FSM is in IDLE, and uld_rx_data, ld_tx_data, regmap_we, regmap_addr, regmap_wdata, tx_data, parity_err_cnt and the packet register are 0.
REQ-037 Reset asserted mid-operation aborts any pending send or write immediately; no strobe is issued after reset_n rises until a new rx word arrives.

Structure
REQ-038 Shared package larpix_pkg holds: packet-declare enum (DATA_OP, TEST_OP, CONFIG_WRITE_OP, CONFIG_READ_OP), field bit-position constants, GLOBAL_ID and the FSM state typedef.
REQ-039 No sub-module; parity is an inline reduction and the FSM plus datapath stay in config_responder.

Verification
REQ-040 chip_id=0; write to address 0x10, data 0xFE -> one regmap_we pulse with addr 0x10, wdata 0xFE; ld_tx_data stays 0.
REQ-041 Read of address 0x10 from chip 0, regmap_rdata=0xFE -> one ld_tx_data pulse; tx_data[1:0]=3, [9:2]=0, [17:10]=0x10, [25:18]=0xFE, [62]=1, odd parity correct.
REQ-042 Read addressed to chip 0x01 while chip_id=0 -> tx_data[62:0] equals rx_data exactly, no regmap activity.
REQ-043 Global (255) read of address 5 -> reply chip ID field=0; global write of address 200 -> ignored.
REQ-044 300 packets each sent with parity_error=1 -> no strobes; parity_err_cnt ends at 255.
REQ-045 tx_busy held at 1 for 1000 cycles during SEND -> ld_tx_data stays 0 and uld_rx_data stays 0 while rx_empty=0; assert reset_n=0 mid-wait -> all outputs 0 and state IDLE.
